// File: rtl/m_dice_pkg.sv
// Shared definitions for the dice pool requester.
// Contents: roll width, request count width, the legal die sizes, the
// requester state encoding, and two helpers: is_legal_sides() checks that a
// die size is supported, and roll_in_range() checks that a roll is 1..sides.
package m_dice_pkg;

    localparam int unsigned ROLL_W = 5;
    localparam int unsigned CNT_W  = 4;

    localparam logic [ROLL_W-1:0] SIDES_D4  = 5'd4;
    localparam logic [ROLL_W-1:0] SIDES_D6  = 5'd6;
    localparam logic [ROLL_W-1:0] SIDES_D8  = 5'd8;
    localparam logic [ROLL_W-1:0] SIDES_D10 = 5'd10;
    localparam logic [ROLL_W-1:0] SIDES_D12 = 5'd12;
    localparam logic [ROLL_W-1:0] SIDES_D20 = 5'd20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // True for the die sizes the roller supports.
    function automatic logic is_legal_sides(input logic [ROLL_W-1:0] sides);
        logic ok;
        ok = 1'b0;
        case (sides)
            SIDES_D4, SIDES_D6, SIDES_D8,
            SIDES_D10, SIDES_D12, SIDES_D20: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    // A roll is valid when it lies in 1..sides.
    function automatic logic roll_in_range(input logic [ROLL_W-1:0] roll,
                                           input logic [ROLL_W-1:0] sides);
        return (roll != '0) && (roll <= sides);
    endfunction

endpackage

// File: rtl/m_dice_pool_sum.sv
// Dice pool requester: accepts "roll N dice of S sides", programs the roller,
// samples its result N times GAP cycles apart, and returns the total.
// Optional feature macro: DICE_MINMAX_EN (tracks smallest/largest sample).
// Ports:
//   clock, reset           rising-edge clock, async active-low reset
//   req_valid/req_ready    request handshake (req_ready decoded from IDLE)
//   req_sides, req_count   die type and number of dice
//   sides                  modulus driven to the roller
//   roll_result            roller output being sampled
//   sum_valid/sum_ready    result handshake
//   sum, err               total of samples, illegal-request/range error flag
//   roll_min, roll_max     sample extremes (0 when the feature is disabled)
module m_dice_pool_sum
    import m_dice_pkg::*;
#(
    parameter int unsigned MAX_DICE = 8,
    parameter int unsigned SUM_W    = 8,
    parameter int unsigned GAP      = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ROLL_W-1:0] req_sides,
    input  logic [CNT_W-1:0]  req_count,
    output logic [ROLL_W-1:0] sides,
    input  logic [ROLL_W-1:0] roll_result,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [SUM_W-1:0]  sum,
    output logic              err,
    output logic [ROLL_W-1:0] roll_min,
    output logic [ROLL_W-1:0] roll_max
);

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    // Worst-case total must fit without saturation.
    if (MAX_DICE * 20 >= (64'd1 << SUM_W)) begin : g_sum_w_check
        $error("m_dice_pool_sum: SUM_W too narrow for MAX_DICE d20 rolls");
    end

    state_e             state_q, state_d;
    logic [ROLL_W-1:0]  sides_q, sides_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               err_q, err_d;
    logic               sum_valid_q, sum_valid_d;
    logic               setup_q, setup_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   left_q, left_d;
    logic               req_legal_c;
`ifdef DICE_MINMAX_EN
    logic [ROLL_W-1:0]  min_q, min_d;
    logic [ROLL_W-1:0]  max_q, max_d;
`endif

    assign req_legal_c = is_legal_sides(req_sides) && (req_count != '0)
                         && (32'(req_count) <= MAX_DICE);

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sides_q     <= '0;
            sum_q       <= '0;
            err_q       <= 1'b0;
            sum_valid_q <= 1'b0;
            setup_q     <= 1'b0;
            gap_q       <= '0;
            left_q      <= '0;
`ifdef DICE_MINMAX_EN
            min_q       <= '0;
            max_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sides_q     <= sides_d;
            sum_q       <= sum_d;
            err_q       <= err_d;
            sum_valid_q <= sum_valid_d;
            setup_q     <= setup_d;
            gap_q       <= gap_d;
            left_q      <= left_d;
`ifdef DICE_MINMAX_EN
            min_q       <= min_d;
            max_q       <= max_d;
`endif
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        sides_d     = sides_q;
        sum_d       = sum_q;
        err_d       = err_q;
        sum_valid_d = sum_valid_q;
        setup_d     = setup_q;
        gap_d       = gap_q;
        left_d      = left_q;
`ifdef DICE_MINMAX_EN
        min_d       = min_q;
        max_d       = max_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sum_d   = '0;
                    left_d  = req_count;
                    setup_d = 1'b0;
                    if (req_legal_c) begin
                        state_d = SETUP;
                        sides_d = req_sides;
                        err_d   = 1'b0;
`ifdef DICE_MINMAX_EN
                        min_d   = '1;
                        max_d   = '0;
`endif
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
`ifdef DICE_MINMAX_EN
                        min_d   = '0;
                        max_d   = '0;
`endif
                    end
                end
            end

            // Two cycles so the roller output reflects the new modulus.
            SETUP: begin
                setup_d = 1'b1;
                if (setup_q) begin
                    state_d = SAMPLE;
                    gap_d   = '0;
                end
            end

            // Sample when the gap counter reaches zero, then reload it.
            SAMPLE: begin
                if (gap_q == '0) begin
                    sum_d  = sum_q + SUM_W'(roll_result);
                    if (!roll_in_range(roll_result, sides_q)) begin
                        err_d = 1'b1;
                    end
`ifdef DICE_MINMAX_EN
                    if (roll_result < min_q) min_d = roll_result;
                    if (roll_result > max_q) max_d = roll_result;
`endif
                    gap_d  = GAP_W'(GAP - 1);
                    left_d = left_q - CNT_W'(1);
                    if (left_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            // Result is presented one cycle after entry and held until taken.
            DONE: begin
                if (!sum_valid_q) begin
                    sum_valid_d = 1'b1;
                end else if (sum_ready) begin
                    sum_valid_d = 1'b0;
                    sides_d     = '0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign sides     = sides_q;
    assign sum       = sum_q;
    assign err       = err_q;
    assign sum_valid = sum_valid_q;

`ifdef DICE_MINMAX_EN
    assign roll_min = min_q;
    assign roll_max = max_q;
`else
    assign roll_min = '0;
    assign roll_max = '0;
`endif

endmodule

// File: tb/tb_m_dice_pool_sum.sv
// Self-checking bench for m_dice_pool_sum: directed cases plus randomized
// requests checked against a cycle-indexed reference model of the sampling.
module tb_m_dice_pool_sum;

    localparam int MAX_DICE = 8;
    localparam int SUM_W    = 8;
    localparam int GAP      = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] req_sides = '0;
    logic [3:0] req_count = '0;
    logic [4:0] sides;
    logic [4:0] roll_result = 5'd1;
    logic       sum_valid;
    logic       sum_ready = 1'b0;
    logic [SUM_W-1:0] sum;
    logic       err;
    logic [4:0] roll_min;
    logic [4:0] roll_max;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int hist[int];       // roll_result value present at each rising edge
    int plan[int];       // forced roll_result values, by edge number
    int plan_q[$];       // rolls for the next transaction's samples
    bit wild = 1'b1;     // allow out-of-range rolls

    m_dice_pool_sum #(.MAX_DICE(MAX_DICE), .SUM_W(SUM_W), .GAP(GAP)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sides   (req_sides),
        .req_count   (req_count),
        .sides       (sides),
        .roll_result (roll_result),
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready),
        .sum         (sum),
        .err         (err),
        .roll_min    (roll_min),
        .roll_max    (roll_max)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [4:0] rand_roll();
        if (wild && $urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(1, 20));
    endfunction

    // Advance one rising edge, log the roll seen there, then drive the next roll.
    task automatic tick();
        @(posedge clock);
        cyc++;
        hist[cyc] = int'(roll_result);
        #1;
        if (plan.exists(cyc + 1)) roll_result = 5'(plan[cyc + 1]);
        else                      roll_result = rand_roll();
    endtask

    function automatic bit legal_req(input int s, input int n);
        return (s == 4 || s == 6 || s == 8 || s == 10 || s == 12 || s == 20)
               && n >= 1 && n <= MAX_DICE;
    endfunction

    task automatic run_txn(input int s, input int n, input int hold,
                           output int o_sum, output bit o_err);
        int e0, t, exp_lat, exp_sum, exp_min, exp_max, v;
        bit legal, exp_err;
        legal = legal_req(s, n);
        e0 = cyc + 1;
        foreach (plan_q[k]) plan[e0 + 3 + k * GAP] = plan_q[k];
        plan_q.delete();

        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_sides = 5'(s);
        req_count = 4'(n);
        tick();
        req_valid = 1'b0;
        req_sides = 5'($urandom);
        req_count = 4'($urandom);
        chk("sides_after_accept", sides, legal ? s : 0);
        chk("req_ready_busy", req_ready, 0);

        t = 0;
        while (!sum_valid && t < 400) begin
            tick();
            t++;
        end
        exp_lat = legal ? e0 + 4 + (n - 1) * GAP : e0 + 1;
        chk("sum_valid_edge", cyc, exp_lat);
        chk("sum_valid_seen", sum_valid, 1);

        // Reference: total and range check over the rolls present at sample edges.
        exp_sum = 0;
        exp_err = !legal;
        exp_min = legal ? 31 : 0;
        exp_max = 0;
        if (legal) begin
            for (int k = 0; k < n; k++) begin
                v = hist.exists(e0 + 3 + k * GAP) ? hist[e0 + 3 + k * GAP] : 0;
                exp_sum += v;
                if (v == 0 || v > s) exp_err = 1'b1;
                if (v < exp_min) exp_min = v;
                if (v > exp_max) exp_max = v;
            end
        end
        chk("sum", sum, exp_sum);
        chk("err", err, exp_err);
`ifdef DICE_MINMAX_EN
        chk("roll_min", roll_min, exp_min);
        chk("roll_max", roll_max, exp_max);
`else
        chk("roll_min_off", roll_min, 0);
        chk("roll_max_off", roll_max, 0);
`endif

        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_sum", sum, exp_sum);
            chk("hold_err", err, exp_err);
            chk("hold_valid", sum_valid, 1);
            chk("hold_req_ready", req_ready, 0);
        end

        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("post_valid", sum_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_sides", sides, 0);
        chk("post_sum_kept", sum, exp_sum);
        chk("post_err_kept", err, exp_err);
        o_sum = int'(sum);
        o_err = err;
    endtask

    initial begin
        int s_got;
        bit e_got;
        int s, n;
        int legal_sides[6] = '{4, 6, 8, 10, 12, 20};

        // Reset values, including req_ready=1 while reset is held.
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_sides", sides, 0);
        chk("rst_sum", sum, 0);
        chk("rst_err", err, 0);
        chk("rst_roll_min", roll_min, 0);
        chk("rst_roll_max", roll_max, 0);
        #11 reset = 1'b1;
        tick();

        // d6 x3 with fixed rolls 2, 5, 6.
        plan_q = '{2, 5, 6};
        run_txn(6, 3, 0, s_got, e_got);
        chk("t1_sum", s_got, 13);
        chk("t1_err", e_got, 0);

        // Illegal die size.
        run_txn(7, 2, 0, s_got, e_got);
        chk("t2_sum", s_got, 0);
        chk("t2_err", e_got, 1);

        // d4 with an out-of-range second roll.
        plan_q = '{3, 5};
        run_txn(4, 2, 0, s_got, e_got);
        chk("t3_sum", s_got, 8);
        chk("t3_err", e_got, 1);

        // Consumer stalls for 10 cycles.
        run_txn(8, 2, 10, s_got, e_got);

        // Reset during SAMPLE after the first of four samples.
        chk("t5_req_ready", req_ready, 1);
        plan[cyc + 4] = 5;
        req_valid = 1'b1;
        req_sides = 5'd6;
        req_count = 4'd4;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk("t5_sum_before_reset", sum, 5);
        reset = 1'b0;
        #1;
        chk("t5_rst_sides", sides, 0);
        chk("t5_rst_sum", sum, 0);
        chk("t5_rst_valid", sum_valid, 0);
        chk("t5_rst_req_ready", req_ready, 1);
        #1 reset = 1'b1;
        run_txn(10, 3, 1, s_got, e_got);

        // Well-behaved d20 x8 roller, repeated.
        wild = 1'b0;
        for (int r = 0; r < 20; r++) begin
            run_txn(20, 8, 0, s_got, e_got);
            chk("t6_err", e_got, 0);
            chk("t6_sum_range", (s_got >= 8 && s_got <= 160) ? 1 : 0, 1);
        end
        wild = 1'b1;

        // Randomized requests, including illegal sizes and counts.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 4) == 0) s = $urandom_range(0, 31);
            else                           s = legal_sides[$urandom_range(0, 5)];
            n = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(1, MAX_DICE);
            run_txn(s, n, $urandom_range(0, 4), s_got, e_got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
